t07_mem_access_unit: RTL and testbench

//  Sequential load/store engine downstream of the control unit: consumes memRead/memWrite/memOp plus ALU address and rs2 data.

---
 rtl/t07_mem_access_unit_pkg.sv | 69 ++++++
 rtl/t07_mem_access_unit_if.sv | 34 +++
 rtl/t07_load_extend.sv | 27 ++
 rtl/t07_mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_t07_mem_access_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/t07_mem_access_unit_pkg.sv
// Shared types and constants for the t07 load/store unit.
// Optional build macro: T07_MEM_TIMEOUT_EN (bus timeout counter and busErr).
package t07_mem_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned LANES           = DATA_W / BYTE_W;
    localparam int unsigned TIMEOUT_DEFAULT = 64;
    localparam logic [31:0] TIMEOUT_WORD    = 32'hDEAD_BEEF;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic mem_size_e op_size(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return SZ_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
            default:                 return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op_size(op))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [LANES-1:0] byte_en(input logic [3:0] op, input logic [1:0] a);
        case (op_size(op))
            SZ_BYTE: return 4'b0001 << a;
            SZ_HALF: return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/t07_mem_access_unit_if.sv
// External data-bus interface for the t07 load/store unit.
// busErr exists only when T07_MEM_TIMEOUT_EN is defined.
interface t07_mem_bus_if #(
    parameter int ADDR_W = 32
) ();

    logic [ADDR_W-1:0] busAddr;
    logic [31:0]       busWData;
    logic [3:0]        busByteEn;
    logic              busRead;
    logic              busWrite;
    logic              busAck;
    logic [31:0]       busRData;
`ifdef T07_MEM_TIMEOUT_EN
    logic              busErr;
`endif

    modport master (
        output busAddr, busWData, busByteEn, busRead, busWrite,
`ifdef T07_MEM_TIMEOUT_EN
        output busErr,
`endif
        input  busAck, busRData
    );

    modport slave (
        input  busAddr, busWData, busByteEn, busRead, busWrite,
`ifdef T07_MEM_TIMEOUT_EN
        input  busErr,
`endif
        output busAck, busRData
    );

endinterface

// File: rtl/t07_load_extend.sv
// Lane select and sign/zero extension of a returned bus word.
module t07_load_extend
    import t07_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [3:0]  op_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword, then extend according to the op
    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = word_i[{lane_i[1], 4'b0000} +: 16];
        case (op_i)
            MEM_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: data_o = {24'd0, byte_sel};
            MEM_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/t07_mem_access_unit.sv
// Sequential load/store engine: one bus transaction per instruction,
// freezes the pipeline while busy, returns the extended load word.
// Optional build macro: T07_MEM_TIMEOUT_EN (WAIT timeout, busErr pulse).
module t07_mem_access_unit
    import t07_mem_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef T07_MEM_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [3:0]        memOp,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       storeData,
    output logic              freeze,
    output logic [31:0]       loadData,
    output logic              misaligned,
    output logic              invalidOp,
    t07_mem_bus_if.master     bus
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [3:0]        op_q, op_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       load_q, load_d;
    logic [31:0]       ext_word;
    logic              req;
    logic              legal;
`ifdef T07_MEM_TIMEOUT_EN
    logic [31:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    t07_load_extend u_ext (
        .word_i (rdata_q),
        .lane_i (addr_q[1:0]),
        .op_i   (op_q),
        .data_o (ext_word)
    );

    assign bus.busAddr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.busByteEn = be_q;
    assign bus.busWData  = wdata_q;
    assign loadData      = load_q;

    // Next-state and output decode; comb outputs forced low while in reset
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        be_d         = be_q;
        op_d         = op_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        load_d       = load_q;
        freeze       = 1'b0;
        misaligned   = 1'b0;
        invalidOp    = 1'b0;
        bus.busRead  = 1'b0;
        bus.busWrite = 1'b0;
`ifdef T07_MEM_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
        bus.busErr   = 1'b0;
`endif
        req   = memRead | memWrite;
        legal = (is_load(memOp) && memRead && !memWrite) ||
                (is_store(memOp) && memWrite && !memRead);

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (!legal) begin
                        invalidOp = 1'b1;
                    end else if (is_misaligned(memOp, addr[1:0])) begin
                        misaligned = 1'b1;
                    end else begin
                        addr_d  = addr;
                        be_d    = byte_en(memOp, addr[1:0]);
                        wdata_d = storeData << {addr[1:0], 3'b000};
                        op_d    = memOp;
                        freeze  = 1'b1;
                        state_d = ST_REQ;
`ifdef T07_MEM_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                    end
                end
            end
            ST_REQ: begin
                freeze       = 1'b1;
                bus.busRead  = is_load(op_q);
                bus.busWrite = is_store(op_q);
                if (bus.busAck) begin
                    rdata_d = bus.busRData;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
`ifdef T07_MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_WAIT: begin
                freeze = 1'b1;
                if (bus.busAck) begin
                    rdata_d = bus.busRData;
                    state_d = ST_DONE;
                end
`ifdef T07_MEM_TIMEOUT_EN
                else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            ST_DONE: begin
                if (is_load(op_q)) begin
`ifdef T07_MEM_TIMEOUT_EN
                    load_d = err_q ? TIMEOUT_WORD : ext_word;
`else
                    load_d = ext_word;
`endif
                end
`ifdef T07_MEM_TIMEOUT_EN
                bus.busErr = err_q;
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            freeze       = 1'b0;
            misaligned   = 1'b0;
            invalidOp    = 1'b0;
            bus.busRead  = 1'b0;
            bus.busWrite = 1'b0;
`ifdef T07_MEM_TIMEOUT_EN
            bus.busErr   = 1'b0;
`endif
        end
    end

    // State and latched transaction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            load_q  <= '0;
`ifdef T07_MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            load_q  <= load_d;
`ifdef T07_MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_t07_mem_access_unit.sv
// Directed bench for t07_mem_access_unit with hand-computed expectations.
// Optional build macro: T07_MEM_TIMEOUT_EN (adds the bus timeout case).
module tb_t07_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead;
    logic        memWrite;
    logic [3:0]  memOp;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic        freeze;
    logic [31:0] loadData;
    logic        misaligned;
    logic        invalidOp;

    int checks = 0;
    int errors = 0;

    int          fz_cnt;
    int          rd_cnt;
    int          wr_cnt;
    logic [3:0]  be_seen;
    logic [31:0] wd_seen;
    logic [31:0] ba_seen;
    bit          done_seen;
    bit          err_seen;

    t07_mem_bus_if #(.ADDR_W(32)) bus ();

    t07_mem_access_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .memOp      (memOp),
        .addr       (addr),
        .storeData  (storeData),
        .freeze     (freeze),
        .loadData   (loadData),
        .misaligned (misaligned),
        .invalidOp  (invalidOp),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it until freeze drops (the DONE cycle).
    // ack_dly = cycles after REQ at which busAck is given (0 = in REQ).
    task automatic txn(input logic rd, input logic wr, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] sd,
                       input int ack_dly, input logic [31:0] word);
        fz_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        be_seen = '0; wd_seen = '0; ba_seen = '0;
        done_seen = 1'b0; err_seen = 1'b0;
        @(negedge clk);
        memRead = rd; memWrite = wr; memOp = op; addr = a; storeData = sd;
        #1;
        if (freeze) fz_cnt++;
        @(negedge clk);
        memRead = 1'b0; memWrite = 1'b0; memOp = '0; addr = '0; storeData = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            bus.busAck   = (cyc == ack_dly);
            bus.busRData = (cyc == ack_dly) ? word : 32'h0BAD_0BAD;
            #1;
            if (bus.busRead)  rd_cnt++;
            if (bus.busWrite) wr_cnt++;
            if (bus.busRead || bus.busWrite) begin
                be_seen = bus.busByteEn;
                wd_seen = bus.busWData;
                ba_seen = bus.busAddr;
            end
            if (!freeze) begin
                done_seen = 1'b1;
`ifdef T07_MEM_TIMEOUT_EN
                err_seen = bus.busErr;
`endif
                break;
            end
            fz_cnt++;
            @(negedge clk);
        end
        bus.busAck = 1'b0;
        bus.busRData = '0;
        check("txn_completes", 32'(done_seen), 32'd1);
        @(negedge clk);
        #1;
    endtask

    // Rejected request: pulse this cycle, nothing started afterwards
    task automatic bad_req(input string tag, input logic rd, input logic wr,
                           input logic [3:0] op, input logic [31:0] a,
                           input logic exp_mis, input logic exp_inv);
        @(negedge clk);
        memRead = rd; memWrite = wr; memOp = op; addr = a;
        #1;
        check({tag, "_misaligned"}, 32'(misaligned), 32'(exp_mis));
        check({tag, "_invalidOp"}, 32'(invalidOp), 32'(exp_inv));
        check({tag, "_freeze"}, 32'(freeze), 32'd0);
        @(negedge clk);
        memRead = 1'b0; memWrite = 1'b0; memOp = '0; addr = '0;
        #1;
        check({tag, "_pulse_end"}, 32'({misaligned, invalidOp}), 32'd0);
        check({tag, "_no_strobe"}, 32'({freeze, bus.busRead, bus.busWrite}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; memOp = '0;
        addr = '0; storeData = '0; bus.busAck = 1'b0; bus.busRData = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_loadData", loadData, 32'd0);
        check("rst_byteEn", 32'(bus.busByteEn), 32'd0);
        check("rst_outputs", 32'({freeze, misaligned, invalidOp, bus.busRead, bus.busWrite}), 32'd0);
        check("rst_busAddr", bus.busAddr, 32'd0);
        rst = 1'b0;

        // lw, ack two cycles after REQ
        txn(1'b1, 1'b0, 4'd3, 32'h100, 32'd0, 2, 32'h1234_5678);
        check("lw_freeze_cycles", fz_cnt, 32'd4);
        check("lw_read_strobes", rd_cnt, 32'd1);
        check("lw_write_strobes", wr_cnt, 32'd0);
        check("lw_byteEn", 32'(be_seen), 32'hF);
        check("lw_busAddr", ba_seen, 32'h100);
        check("lw_loadData", loadData, 32'h1234_5678);
        check("lw_freeze_released", 32'(freeze), 32'd0);

        // lb on top lane, zero-wait memory (minimum latency)
        txn(1'b1, 1'b0, 4'd1, 32'h103, 32'd0, 0, 32'h80FF_FFFF);
        check("lb_freeze_cycles", fz_cnt, 32'd2);
        check("lb_byteEn", 32'(be_seen), 32'h8);
        check("lb_busAddr", ba_seen, 32'h100);
        check("lb_loadData", loadData, 32'hFFFF_FF80);

        txn(1'b1, 1'b0, 4'd4, 32'h103, 32'd0, 1, 32'h80FF_FFFF);
        check("lbu_byteEn", 32'(be_seen), 32'h8);
        check("lbu_loadData", loadData, 32'h0000_0080);

        txn(1'b1, 1'b0, 4'd2, 32'h102, 32'd0, 1, 32'h8001_1234);
        check("lh_byteEn", 32'(be_seen), 32'hC);
        check("lh_loadData", loadData, 32'hFFFF_8001);

        txn(1'b1, 1'b0, 4'd5, 32'h100, 32'd0, 0, 32'hFEDC_9876);
        check("lhu_byteEn", 32'(be_seen), 32'h3);
        check("lhu_loadData", loadData, 32'h0000_9876);

        // Stores: lane shift, byte enables, loadData untouched
        txn(1'b0, 1'b1, 4'd7, 32'h202, 32'h0000_ABCD, 1, 32'd0);
        check("sh_wdata", wd_seen, 32'hABCD_0000);
        check("sh_byteEn", 32'(be_seen), 32'hC);
        check("sh_write_strobes", wr_cnt, 32'd1);
        check("sh_read_strobes", rd_cnt, 32'd0);
        check("sh_busAddr", ba_seen, 32'h200);
        check("sh_loadData_kept", loadData, 32'h0000_9876);

        txn(1'b0, 1'b1, 4'd6, 32'h201, 32'h0000_00EE, 0, 32'd0);
        check("sb_wdata", wd_seen, 32'h0000_EE00);
        check("sb_byteEn", 32'(be_seen), 32'h2);

        txn(1'b0, 1'b1, 4'd8, 32'h204, 32'h1122_3344, 3, 32'd0);
        check("sw_wdata", wd_seen, 32'h1122_3344);
        check("sw_byteEn", 32'(be_seen), 32'hF);
        check("sw_busAddr", ba_seen, 32'h204);
        check("sw_freeze_cycles", fz_cnt, 32'd5);
        check("sw_loadData_kept", loadData, 32'h0000_9876);

        // Rejected requests
        bad_req("lw_mis", 1'b1, 1'b0, 4'd3, 32'h101, 1'b1, 1'b0);
        bad_req("lh_mis", 1'b1, 1'b0, 4'd2, 32'h103, 1'b1, 1'b0);
        bad_req("sb_as_read", 1'b1, 1'b0, 4'd6, 32'h100, 1'b0, 1'b1);
        bad_req("op9_write", 1'b0, 1'b1, 4'd9, 32'h100, 1'b0, 1'b1);
        bad_req("rd_and_wr", 1'b1, 1'b1, 4'd3, 32'h100, 1'b0, 1'b1);
        check("reject_loadData_kept", loadData, 32'h0000_9876);

        // Reset while waiting for the bus
        @(negedge clk);
        memRead = 1'b1; memOp = 4'd3; addr = 32'h300;
        @(negedge clk);
        memRead = 1'b0; memOp = '0; addr = '0;
        @(negedge clk);
        #1;
        check("wait_freeze", 32'(freeze), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstwait_outputs", 32'({freeze, bus.busRead, bus.busWrite}), 32'd0);
        check("rstwait_loadData", loadData, 32'd0);
        rst = 1'b0;
        bus.busAck = 1'b1; bus.busRData = 32'h5555_5555;
        @(negedge clk);
        bus.busAck = 1'b0; bus.busRData = '0;
        #1;
        check("late_ack_ignored", 32'({freeze, bus.busRead, bus.busWrite}), 32'd0);
        @(negedge clk);
        #1;
        check("late_ack_loadData", loadData, 32'd0);

        txn(1'b1, 1'b0, 4'd3, 32'h104, 32'd0, 0, 32'hCAFE_F00D);
        check("post_rst_lw", loadData, 32'hCAFE_F00D);

`ifdef T07_MEM_TIMEOUT_EN
        txn(1'b1, 1'b0, 4'd3, 32'h400, 32'd0, 1000, 32'd0);
        check("to_freeze_cycles", fz_cnt, 32'd66);
        check("to_busErr", 32'(err_seen), 32'd1);
        check("to_loadData", loadData, 32'hDEAD_BEEF);
        check("to_freeze_released", 32'(freeze), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
